// File: rtl/axi_read_master.sv
// Single-beat AXI read master: one request in IDLE -> AR handshake -> R capture -> one-cycle ready pulse.
// Latency 3 cycles minimum; ARREADY/RVALID stalls hold ADDR/DATA indefinitely, new requests ignored while busy.
module axi_read_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              ACLK,
  input  logic              ARESET,
  output logic [ADDR_W-1:0] ARADDR,
  output logic              ARVALID,
  input  logic              ARREADY,
  input  logic [DATA_W-1:0] RDATA,
  input  logic [1:0]        RRESP,
  input  logic              RVALID,
  output logic              RREADY,
  input  logic              valid,
  input  logic [ADDR_W-1:0] ar_addr,
  output logic [DATA_W-1:0] r_data,
  output logic [1:0]        r_resp,
  output logic              ready,
  output logic              busy,
  output logic [15:0]       rd_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state;

  always_ff @(posedge ACLK or negedge ARESET) begin
    if (!ARESET) begin
      state    <= IDLE;
      ARADDR   <= '0;
      ARVALID  <= 1'b0;
      RREADY   <= 1'b0;
      r_data   <= '0;
      r_resp   <= 2'b00;
      ready    <= 1'b0;
      busy     <= 1'b0;
      rd_count <= 16'd0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (valid) begin
            ARADDR  <= ar_addr;
            ARVALID <= 1'b1;
            busy    <= 1'b1;
            state   <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY) begin
            ARVALID <= 1'b0;
            RREADY  <= 1'b1;
            state   <= DATA;
          end
        end
        DATA: begin
          // Count and pulse are registered here so both are visible during DONE.
          if (RVALID) begin
            r_data   <= RDATA;
            r_resp   <= RRESP;
            RREADY   <= 1'b0;
            ready    <= 1'b1;
            rd_count <= rd_count + 16'd1;
            state    <= DONE;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  a_ar_r_exclusive: assert property (@(posedge ACLK) disable iff (!ARESET)
    !(ARVALID && RREADY));

  a_ar_stable: assert property (@(posedge ACLK) disable iff (!ARESET)
    (ARVALID && !ARREADY) |=> (ARVALID && $stable(ARADDR)));

endmodule

// File: doc/axi_read_master.md
AXI_READ_MASTER -- requirements
Module: axi_read_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AXI read address width.
REQ-002 SHALL have parameter DATA_W, default 32, AXI read data width.
REQ-003 SHALL have port ACLK  input  1  single clock; all sequential logic on rising edge.
REQ-004 SHALL have port ARESET  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port ARADDR  output  ADDR_W  AR channel address.
REQ-006 SHALL have port ARVALID  output  1  AR channel valid.
REQ-007 SHALL have port ARREADY  input  1  AR channel ready from slave.
REQ-008 SHALL have port RDATA  input  DATA_W  R channel data.
REQ-009 SHALL have port RRESP  input  2  R channel response.
REQ-010 SHALL have port RVALID  input  1  R channel valid.
REQ-011 SHALL have port RREADY  output  1  R channel ready.
REQ-012 SHALL have port valid  input  1  external read request strobe.
REQ-013 SHALL have port ar_addr  input  ADDR_W  external read address.
REQ-014 SHALL have port r_data  output  DATA_W  captured read data.
REQ-015 SHALL have port r_resp  output  2  captured read response.
REQ-016 SHALL have port ready  output  1  one-cycle read-complete pulse.
REQ-017 SHALL have port busy  output  1  high whenever FSM is not IDLE.
REQ-018 SHALL have port rd_count  output  16  count of completed reads.

Function
REQ-019 SHALL implement FSM states IDLE, ADDR, DATA, DONE.
REQ-020 IDLE: on valid=1 at a rising edge, SHALL latch ar_addr into ARADDR unmodified (no alignment), assert ARVALID, and enter ADDR.
REQ-021 valid SHALL be ignored in every state other than IDLE; no request queueing.
REQ-022 ADDR: ARVALID SHALL stay 1 and ARADDR stable until a rising edge with ARVALID=1 and ARREADY=1.
REQ-023 ADDR: on that handshake edge, SHALL deassert ARVALID, assert RREADY, and enter DATA.
REQ-024 DATA: RREADY SHALL stay 1 until a rising edge with RVALID=1.
REQ-025 DATA: on that edge, SHALL capture RDATA into r_data and RRESP into r_resp, deassert RREADY, and enter DONE.
REQ-026 RVALID asserted while not in DATA SHALL be ignored; r_data/r_resp unchanged.
REQ-027 DONE: ready SHALL be 1 for exactly one cycle, rd_count SHALL increment by 1 (wrap 16'hFFFF -> 0), and the FSM SHALL return to IDLE.
REQ-028 r_data and r_resp SHALL hold their value until the next DATA-state capture.
REQ-029 Minimum latency SHALL be 3 cycles: valid sampled at edge N, ARREADY=1 gives handshake at N+1, RVALID=1 at N+2, ready high after N+2 until N+3.
REQ-030 Slave stalls SHALL extend ADDR/DATA indefinitely; no timeout and no protocol-violating abort.
REQ-031 ARVALID and RREADY SHALL never both be 1 in the same cycle.
REQ-032 valid=1 during DONE SHALL be ignored; a new request SHALL be accepted only in IDLE (earliest the edge after ready).

Reset
REQ-033 ARESET=0 SHALL immediately, without a clock, force FSM to IDLE and ARADDR=0, ARVALID=0, RREADY=0, r_data=0, r_resp=0, ready=0, busy=0, rd_count=0.
REQ-034 Reset asserted mid-transaction (ADDR or DATA) SHALL abandon it with no ready pulse and no rd_count change.
REQ-035 After ARESET returns to 1, the first request SHALL be accepted at the first rising edge with valid=1.

Verification
REQ-036 Zero-wait read: ar_addr=0x0, valid one cycle, ARREADY=1, slave RVALID=1 with RDATA=0x12345678 RRESP=0 the cycle after handshake -> r_data=0x12345678, r_resp=0, ready pulse 3 cycles after valid, rd_count=1.
REQ-037 AR stall: ar_addr=0x7, ARREADY held 0 for 5 cycles -> ARVALID=1 and ARADDR=0x7 stable all 5 cycles; completion after ARREADY=1 as in REQ-036.
REQ-038 R stall plus error: RVALID delayed 4 cycles, RDATA=0xDEADBEEF RRESP=2'b10 -> RREADY high throughout wait, r_data=0xDEADBEEF, r_resp=2'b10, single ready pulse.
REQ-039 Ignored request: valid=1 with ar_addr=0x3 while in DATA -> ARADDR unchanged, no second AR handshake, rd_count increments by exactly 1.
REQ-040 Reset mid-read: ARESET=0 while in DATA -> all outputs 0 immediately; after release, read of ar_addr=0x1 completes normally with rd_count=1.
REQ-041 Back-to-back: 3 reads issued each in the cycle after ready -> three ready pulses, rd_count=3, r_data equals last RDATA.
